vga_pattern_gen: RTL

- Parametrised successor to the fixed colour-stripe generator: a self-timed VGA test-pattern source with its own raster counters.
- Selectable patterns: horizontal bars, vertical bars, checkerboard, grey gradient, solid colour.
- Multi-bit colour channels and optional per-frame scrolling.
- Sits between the pixel clock and the VGA pins; replaces the stripe generator plus its external counter.

---
 rtl/vga_pattern_gen.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen.sv
// Self-timed VGA test-pattern source: raster counters, sync generation and
// five selectable patterns. All outputs are registered one clock behind the counters.
module vga_pattern_gen #(
  parameter int COLOR_BITS = 1,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BAND_SIZE  = 100,
  parameter int CHECK_LOG2 = 5,
  parameter int GRAD_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              i_mode,
  input  logic                    i_scroll_en,
  input  logic [3*COLOR_BITS-1:0] i_solid_rgb,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic [COLOR_BITS-1:0]   o_red,
  output logic [COLOR_BITS-1:0]   o_green,
  output logic [COLOR_BITS-1:0]   o_blue,
  output logic                    o_active,
  output logic                    o_frame_start
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int BW       = (BAND_SIZE > 1) ? $clog2(BAND_SIZE) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [COLOR_BITS-1:0] FULL = '1;
  localparam logic [BW-1:0] SUB_LAST = BW'(BAND_SIZE - 1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [BW-1:0] r_hsub;
  logic [BW-1:0] r_vsub;
  logic [HW-1:0] r_hband;
  logic [VW-1:0] r_vband;
  logic [15:0]   r_frame;
  logic [2:0]    r_mode;

  logic [31:0]           w_x;
  logic [31:0]           w_y;
  logic                  w_h_last;
  logic                  w_v_last;
  logic                  w_origin;
  logic                  w_active;
  logic [2:0]            w_mode;
  logic [2:0]            w_kx;
  logic [2:0]            w_ky;
  logic                  w_chk;
  logic [COLOR_BITS-1:0] w_grey;
  logic [COLOR_BITS-1:0] w_r;
  logic [COLOR_BITS-1:0] w_g;
  logic [COLOR_BITS-1:0] w_b;

  assign w_x      = 32'(r_h);
  assign w_y      = 32'(r_v);
  assign w_h_last = (w_x == 32'(H_TOTAL - 1));
  assign w_v_last = (w_y == 32'(V_TOTAL - 1));
  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_active = (w_x < 32'(H_ACTIVE)) && (w_y < 32'(V_ACTIVE));

  // The new mode is visible already at pixel (0,0), the same clock it is latched.
  assign w_mode = w_origin ? i_mode : r_mode;

  // Band indices come from running counters, so no divider is needed.
  assign w_kx   = 3'(32'(r_hband) + 32'(r_frame));
  assign w_ky   = 3'(32'(r_vband) + 32'(r_frame));
  assign w_chk  = (((w_x >> CHECK_LOG2) ^ ((w_y + 32'(r_frame)) >> CHECK_LOG2)) & 32'd1) != 32'd0;
  assign w_grey = COLOR_BITS'((w_x + 32'(r_frame)) >> GRAD_SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h     <= '0;
      r_v     <= '0;
      r_hsub  <= '0;
      r_vsub  <= '0;
      r_hband <= '0;
      r_vband <= '0;
      r_frame <= '0;
      r_mode  <= '0;
    end else begin
      if (w_origin) r_mode <= i_mode;
      if (w_h_last) begin
        r_h     <= '0;
        r_hsub  <= '0;
        r_hband <= '0;
        if (w_v_last) begin
          r_v     <= '0;
          r_vsub  <= '0;
          r_vband <= '0;
          if (i_scroll_en) r_frame <= r_frame + 16'd1;
        end else begin
          r_v <= r_v + 1'b1;
          if (r_vsub == SUB_LAST) begin
            r_vsub  <= '0;
            r_vband <= r_vband + 1'b1;
          end else begin
            r_vsub <= r_vsub + 1'b1;
          end
        end
      end else begin
        r_h <= r_h + 1'b1;
        if (r_hsub == SUB_LAST) begin
          r_hsub  <= '0;
          r_hband <= r_hband + 1'b1;
        end else begin
          r_hsub <= r_hsub + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_mode)
      3'd0: begin
        w_r = w_ky[0] ? FULL : '0;
        w_g = w_ky[1] ? FULL : '0;
        w_b = w_ky[2] ? FULL : '0;
      end
      3'd1: begin
        w_r = w_kx[0] ? FULL : '0;
        w_g = w_kx[1] ? FULL : '0;
        w_b = w_kx[2] ? FULL : '0;
      end
      3'd2: begin
        w_r = w_chk ? FULL : '0;
        w_g = w_chk ? FULL : '0;
        w_b = w_chk ? FULL : '0;
      end
      3'd3: begin
        w_r = w_grey;
        w_g = w_grey;
        w_b = w_grey;
      end
      3'd4: begin
        w_r = i_solid_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
        w_g = i_solid_rgb[2*COLOR_BITS-1:COLOR_BITS];
        w_b = i_solid_rgb[COLOR_BITS-1:0];
      end
      default: ;
    endcase
    if (!w_active) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= !((w_x >= 32'(HS_START)) && (w_x < 32'(HS_END)));
      o_vsync       <= !((w_y >= 32'(VS_START)) && (w_y < 32'(VS_END)));
      o_red         <= w_r;
      o_green       <= w_g;
      o_blue        <= w_b;
      o_active      <= w_active;
      o_frame_start <= w_origin;
    end
  end
endmodule
